pipeline_ctrl: RTL
==================

# pipeline_ctrl

Pipeline control responder for the 5-stage RV32I core. Consumes the decode-stage `stall` request, the execute-stage redirect and the data-memory handshake, and drives per-stage register enables, flushes and bubbles. Applies a fixed priority among these sources and freezes the whole pipeline while a data access is outstanding. Also keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
Parameters:
- `CNT_W`, 32, width of each performance counter
- `TIMEOUT_CYC`, 1024, memory-wait cycles before `mem_timeout` sets (≥2)

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  decode-stage stall request: load-use or fence
- `redirect_e`  in  1  branch/jump taken in EX; fetch must restart
- `dmem_req_m`  in  1  MEM stage issues a load/store this cycle
- `dmem_ack`  in  1  data memory completes the outstanding/current access
- `perf_clr`  in  1  synchronous clear of all performance counters
- `pc_en`  out  1  PC register update enable
- `ifid_en`  out  1  IF/ID register enable
- `ifid_flush`  out  1  IF/ID loads a NOP
- `idex_en`  out  1  ID/EX register enable
- `idex_flush`  out  1  ID/EX loads a NOP (bubble)
- `exmem_en`  out  1  EX/MEM register enable
- `memwb_en`  out  1  MEM/WB register enable
- `mem_wait`  out  1  high while in MEM_WAIT
- `mem_timeout`  out  1  sticky: an access exceeded `TIMEOUT_CYC`
- `cnt_load_stall`  out  CNT_W  cycles with a stall bubble inserted
- `cnt_mem_wait`  out  CNT_W  cycles the pipeline was frozen for memory
- `cnt_flush`  out  CNT_W  redirect flushes applied

## Operation
- FSM states: RUN, MEM_WAIT. Reset state RUN.
- Freeze condition: `freeze = (RUN & dmem_req_m & ~dmem_ack) | (MEM_WAIT & ~dmem_ack)`.
- Transitions:
  - RUN→MEM_WAIT when `dmem_req_m & ~dmem_ack`.
  - MEM_WAIT→RUN when `dmem_ack`.
  - Otherwise stay.
- Output priority, highest first:
  1. `freeze`: all `*_en`=0 and all flushes=0. Every register holds. `redirect_e` and `stall` are ignored; they stay asserted because their source stages are held.
  2. `redirect_e`: `pc_en`=1, `ifid_en`=1, `ifid_flush`=1, `idex_en`=1, `idex_flush`=1, `exmem_en`=1, `memwb_en`=1. A redirect overrides a coincident `stall`, because the stalled decode instruction is wrong-path.
  3. `stall`: `pc_en`=0, `ifid_en`=0, `idex_en`=1, `idex_flush`=1, `exmem_en`=1, `memwb_en`=1.
  4. Otherwise all enables 1 and all flushes 0.
- Outputs 1–4 are combinational from state and inputs. `mem_wait` = (state==MEM_WAIT).
- Ack cycle in MEM_WAIT: `freeze`=0, so priorities 2–4 apply in that same cycle.
- Timeout counter:
  - Cleared on entering MEM_WAIT; increments each MEM_WAIT cycle without ack.
  - At count == `TIMEOUT_CYC`-1 with no ack, `mem_timeout` sets on the next edge.
  - The counter then stops and the block keeps waiting (no abort).
  - `mem_timeout` clears only on reset.
- Perf counters:
  - `cnt_load_stall` increments on cycles where priority 3 applies.
  - `cnt_mem_wait` increments on cycles where `freeze`=1.
  - `cnt_flush` increments on cycles where priority 2 applies.
  - All saturate at all-ones.
  - `perf_clr` clears all three and wins over a same-cycle increment.

## Timing
- While `rst_n`=0, outputs are forced regardless of inputs:
  - all `*_en`=0
  - `ifid_flush`=1, `idex_flush`=1
  - `mem_wait`=0, `mem_timeout`=0
  - counters 0
- Reset asserted mid-MEM_WAIT: state returns to RUN immediately and the timeout count is dropped.
- Latency: control outputs are zero-cycle, same cycle as the inputs. State, counters and `mem_timeout` update on the rising edge.
- Single-cycle access (`dmem_req_m & dmem_ack` in RUN): no freeze, no state change, `cnt_mem_wait` unchanged.
- N-cycle access: request plus (N-1) cycles without ack, then ack. `freeze` is high for exactly N-1 cycles.
- `dmem_req_m` in MEM_WAIT is don't-care; the same access is being held.

## Test plan
- Reset then idle: during `rst_n`=0, enables=0 and flushes=1. One cycle after release, all enables=1 and flushes=0.
- `stall`=1 for 1 cycle: `pc_en`=`ifid_en`=0, `idex_flush`=1. Then `cnt_load_stall`=1.
- `stall`=1 together with `redirect_e`=1: flush outputs as priority 2, `pc_en`=1. `cnt_flush`=1 and `cnt_load_stall`=0.
- Request followed by ack 3 cycles later: `mem_wait` high for 3 cycles and all enables 0 for 3 cycles. Priority 3 applies on the ack cycle when `stall`=1 and `redirect_e`=0. Then `cnt_mem_wait`=3.
- `TIMEOUT_CYC`=4, request with no ack for 6 cycles: `mem_timeout` rises after the 4th MEM_WAIT cycle. It stays 1 after the ack and is cleared by reset.
- Counter at all-ones with an increment: stays all-ones. `perf_clr` in the same cycle as an increment gives 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/flush/freeze responder for the 5-stage RV32I pipeline.
// Resolves freeze > redirect > stall > run into per-stage enables and flushes,
// tracks outstanding data accesses, and keeps saturating performance counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_e,
    input  logic             dmem_req_m,
    input  logic             dmem_ack,
    input  logic             perf_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             mem_wait,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cnt_load_stall,
    output logic [CNT_W-1:0] cnt_mem_wait,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic             freeze_c;
    logic             redir_act_c;
    logic             stall_act_c;

    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] cnt_load_stall_q, cnt_load_stall_d;
    logic [CNT_W-1:0] cnt_mem_wait_q, cnt_mem_wait_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

    // Saturating increment: all-ones is sticky.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Hazard classification; priority resolved here and shared by outputs and counters.
    assign freeze_c    = (state_q == RUN) ? (dmem_req_m & ~dmem_ack) : ~dmem_ack;
    assign redir_act_c = ~freeze_c & redirect_e;
    assign stall_act_c = ~freeze_c & ~redirect_e & stall;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter MEM_WAIT on an unacked request, leave on ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (dmem_req_m && !dmem_ack) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ack) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Control outputs: zero-latency, forced to a safe flushed value while in reset.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        mem_wait   = (state_q == MEM_WAIT);
        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_en    = 1'b0;
            idex_flush = 1'b1;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            mem_wait   = 1'b0;
        end else if (freeze_c) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (redir_act_c) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall_act_c) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Memory timeout: count unacked MEM_WAIT cycles, latch a sticky flag at the limit.
    always_comb begin
        tmo_cnt_d     = tmo_cnt_q;
        mem_timeout_d = mem_timeout_q;
        if (state_q == RUN) begin
            if (dmem_req_m && !dmem_ack) tmo_cnt_d = '0;
        end else if (!dmem_ack) begin
            if (tmo_cnt_q == TMO_LAST) begin
                mem_timeout_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end
    end

    // Performance counters: clear wins over a same-cycle increment.
    always_comb begin
        cnt_load_stall_d = cnt_load_stall_q;
        cnt_mem_wait_d   = cnt_mem_wait_q;
        cnt_flush_d      = cnt_flush_q;
        if (perf_clr) begin
            cnt_load_stall_d = '0;
            cnt_mem_wait_d   = '0;
            cnt_flush_d      = '0;
        end else begin
            if (stall_act_c) cnt_load_stall_d = sat_inc(cnt_load_stall_q);
            if (freeze_c)    cnt_mem_wait_d   = sat_inc(cnt_mem_wait_q);
            if (redir_act_c) cnt_flush_d      = sat_inc(cnt_flush_q);
        end
    end

    // Timeout and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q        <= '0;
            mem_timeout_q    <= 1'b0;
            cnt_load_stall_q <= '0;
            cnt_mem_wait_q   <= '0;
            cnt_flush_q      <= '0;
        end else begin
            tmo_cnt_q        <= tmo_cnt_d;
            mem_timeout_q    <= mem_timeout_d;
            cnt_load_stall_q <= cnt_load_stall_d;
            cnt_mem_wait_q   <= cnt_mem_wait_d;
            cnt_flush_q      <= cnt_flush_d;
        end
    end

    assign mem_timeout    = mem_timeout_q;
    assign cnt_load_stall = cnt_load_stall_q;
    assign cnt_mem_wait   = cnt_mem_wait_q;
    assign cnt_flush      = cnt_flush_q;

endmodule
